// File: rtl/ieeedrv_rom_loader.sv
// ---------------------------------------------------------------------------
// ieeedrv_rom_loader
//
// Purpose:
//   Copies a drive DOS ROM image from the host download stream into the
//   shared drive ROM write port (port B), one byte per cycle. Short images
//   are padded with FILL up to ROM_SIZE bytes. All drive CPUs are held in
//   reset until the complete ROM (image plus padding) has been written.
//
// Parameters:
//   ADDRWIDTH  ROM address width (must match the ROM and the read mux)
//   ROM_SIZE   number of ROM bytes, <= 2**ADDRWIDTH
//   FILL       byte written to every address not covered by the image
//
// Ports:
//   clk             in   system clock
//   reset           in   synchronous, active-high reset
//   ioctl_download  in   high while a ROM image download is in progress
//   ioctl_wr        in   byte strobe, qualified by ioctl_download
//   ioctl_data      in   download byte
//   rom_addr        out  ROM write address
//   rom_data        out  ROM write data
//   rom_wren        out  ROM write enable, one cycle per byte
//   drv_hold        out  holds all drive CPUs in reset while high
//   loaded          out  complete image (including padding) is in ROM
//   overflow        out  image exceeded ROM_SIZE; cleared on next download
//   rom_len         out  number of image bytes written (padding excluded)
// ---------------------------------------------------------------------------
module ieeedrv_rom_loader #(
  parameter int         ADDRWIDTH = 14,
  parameter int         ROM_SIZE  = 16384,
  parameter logic [7:0] FILL      = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [7:0]           ioctl_data,
  output logic [ADDRWIDTH-1:0] rom_addr,
  output logic [7:0]           rom_data,
  output logic                 rom_wren,
  output logic                 drv_hold,
  output logic                 loaded,
  output logic                 overflow,
  output logic [ADDRWIDTH:0]   rom_len
);

  // Counter is one bit wider than the address so it can hold ROM_SIZE itself.
  localparam logic [ADDRWIDTH:0] C_ROM_SIZE = (ADDRWIDTH + 1)'(ROM_SIZE);
  localparam logic [ADDRWIDTH:0] C_ONE      = (ADDRWIDTH + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [ADDRWIDTH:0]     r_cnt;
  logic                   r_dl_q;
  logic [ADDRWIDTH-1:0]   r_addr;
  logic [7:0]             r_data;
  logic                   r_wren;
  logic                   r_hold;
  logic                   r_loaded;
  logic                   r_ovf;
  logic [ADDRWIDTH:0]     r_len;

  state_t                 w_state_nxt;
  logic [ADDRWIDTH:0]     w_cnt_nxt;
  logic [ADDRWIDTH-1:0]   w_addr_nxt;
  logic [7:0]             w_data_nxt;
  logic                   w_wren_nxt;
  logic                   w_hold_nxt;
  logic                   w_loaded_nxt;
  logic                   w_ovf_nxt;
  logic [ADDRWIDTH:0]     w_len_nxt;

  logic                   w_dl_rise;
  logic                   w_full;

  // A new download is recognised only on a rising edge of ioctl_download, so
  // a download left high across a reset is never mistaken for a fresh one.
  assign w_dl_rise = ioctl_download & ~r_dl_q;
  assign w_full    = (r_cnt == C_ROM_SIZE);

  // Next-state and next-output logic for the load/fill sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_wren_nxt   = 1'b0;
    w_hold_nxt   = r_hold;
    w_loaded_nxt = r_loaded;
    w_ovf_nxt    = r_ovf;
    w_len_nxt    = r_len;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_dl_rise) begin
          w_state_nxt  = ST_LOAD;
          w_cnt_nxt    = '0;
          w_ovf_nxt    = 1'b0;
          w_loaded_nxt = 1'b0;
          w_hold_nxt   = 1'b1;
        end else begin
          w_state_nxt  = r_state;
        end
      end

      ST_LOAD: begin
        // The fall takes priority: a strobe in the same cycle is not qualified.
        if (!ioctl_download) begin
          w_len_nxt   = r_cnt;
          w_state_nxt = ST_FILL;
        end else if (ioctl_wr) begin
          if (!w_full) begin
            w_wren_nxt = 1'b1;
            w_addr_nxt = r_cnt[ADDRWIDTH-1:0];
            w_data_nxt = ioctl_data;
            w_cnt_nxt  = r_cnt + C_ONE;
          end else begin
            w_ovf_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end

      ST_FILL: begin
        if (!w_full) begin
          w_wren_nxt = 1'b1;
          w_addr_nxt = r_cnt[ADDRWIDTH-1:0];
          w_data_nxt = FILL;
          w_cnt_nxt  = r_cnt + C_ONE;
        end else begin
          // The last write was issued on the previous edge, so releasing the
          // drives here can never overlap a pending ROM write.
          w_state_nxt  = ST_DONE;
          w_loaded_nxt = 1'b1;
          w_hold_nxt   = 1'b0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    r_dl_q <= ioctl_download;
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= 8'h00;
      r_wren   <= 1'b0;
      r_hold   <= 1'b1;
      r_loaded <= 1'b0;
      r_ovf    <= 1'b0;
      r_len    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_wren   <= w_wren_nxt;
      r_hold   <= w_hold_nxt;
      r_loaded <= w_loaded_nxt;
      r_ovf    <= w_ovf_nxt;
      r_len    <= w_len_nxt;
    end
  end

  assign rom_addr = r_addr;
  assign rom_data = r_data;
  assign rom_wren = r_wren;
  assign drv_hold = r_hold;
  assign loaded   = r_loaded;
  assign overflow = r_ovf;
  assign rom_len  = r_len;

endmodule

// File: tb/tb_ieeedrv_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_ieeedrv_rom_loader
//
// Self-checking bench for ieeedrv_rom_loader with a 16-byte ROM. A monitor
// records every ROM write; after each download the recorded writes are
// compared with the image the bench sent (first ROM_SIZE bytes, then FILL).
// ---------------------------------------------------------------------------
module tb_ieeedrv_rom_loader;

  localparam int         AW = 4;
  localparam int         RS = 16;
  localparam logic [7:0] FB = 8'hFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [7:0]    ioctl_data;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_wren;
  logic          drv_hold;
  logic          loaded;
  logic          overflow;
  logic [AW:0]   rom_len;

  ieeedrv_rom_loader #(
    .ADDRWIDTH (AW),
    .ROM_SIZE  (RS),
    .FILL      (FB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_data     (ioctl_data),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_wren       (rom_wren),
    .drv_hold       (drv_hold),
    .loaded         (loaded),
    .overflow       (overflow),
    .rom_len        (rom_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          hold;
    logic          ld;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] sent[$];
  int         scyc[$];

  // Record every ROM write, away from the active edge.
  always @(negedge clk) begin
    if (rom_wren === 1'b1) wq.push_back('{cyc, rom_addr, rom_data, drv_hold, loaded});
  end

  typedef struct {
    int         n;
    int         gap;
    int         hold;
    bit         fall_strobe;
    logic [7:0] base;
    int         exp_len;
    bit         exp_ovf;
    int         exp_fill;
  } vec_t;

  vec_t tbl[5];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl();
    chk("idle_writes", wq.size(), 0);
    wq.delete();
    sent.delete();
    scyc.delete();
    ioctl_download = 1'b1;
    step();
    chk("start_loaded", {31'd0, loaded}, 0);
    chk("start_hold", {31'd0, drv_hold}, 1);
    chk("start_overflow", {31'd0, overflow}, 0);
  endtask

  task automatic strobe(input logic [7:0] d, input int gap);
    ioctl_wr   = 1'b1;
    ioctl_data = d;
    sent.push_back(d);
    scyc.push_back(cyc);
    step();
    ioctl_wr = 1'b0;
    if (sent.size() == RS)     chk("overflow_at_limit", {31'd0, overflow}, 0);
    if (sent.size() == RS + 1) chk("overflow_17th", {31'd0, overflow}, 1);
    repeat (gap) step();
  endtask

  task automatic finish_dl(input int hold, input bit fall_strobe, input int exp_len,
                           input bit exp_ovf, input int exp_fill);
    int fall_cyc;
    int lcyc;
    int k;
    logic [7:0] exp_d;
    repeat (hold) step();
    if (fall_strobe) begin
      ioctl_wr   = 1'b1;
      ioctl_data = 8'h5A;
    end
    ioctl_download = 1'b0;
    fall_cyc = cyc;
    step();
    ioctl_wr = 1'b0;
    k = 0;
    while (loaded !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    lcyc = cyc;
    chk("loaded_timeout", {31'd0, loaded}, 1);
    chk("drv_hold_done", {31'd0, drv_hold}, 0);
    chk("rom_len", {27'd0, rom_len}, exp_len);
    chk("overflow_done", {31'd0, overflow}, {31'd0, exp_ovf});
    chk("write_count", wq.size(), RS);
    chk("fill_count", wq.size() - exp_len, exp_fill);
    for (int i = 0; i < wq.size(); i++) begin
      exp_d = (i < exp_len) ? sent[i] : FB;
      chk("wr_addr", {28'd0, wq[i].addr}, i);
      chk("wr_data", {24'd0, wq[i].data}, {24'd0, exp_d});
      chk("wr_guard", {30'd0, wq[i].hold, wq[i].ld}, 2);
      if (i < exp_len)       chk("wr_latency", wq[i].cyc, scyc[i] + 1);
      else if (i == exp_len) chk("fill_start", wq[i].cyc, fall_cyc + 2);
      else                   chk("fill_rate", wq[i].cyc, wq[i-1].cyc + 1);
    end
    if (exp_fill > 0 && wq.size() > 0) chk("loaded_cycle", lcyc, wq[wq.size()-1].cyc + 1);
    else                               chk("loaded_cycle", lcyc, fall_cyc + 2);
    wq.delete();
    // Stray strobes with no download in progress must not write.
    ioctl_wr = 1'b1;
    ioctl_data = 8'h77;
    step();
    step();
    ioctl_wr = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int elen;
    bit fs;
    tbl[0] = '{16, 0, 0, 1'b0, 8'h00, 16, 1'b0, 0};
    tbl[1] = '{ 5, 2, 0, 1'b0, 8'hA0,  5, 1'b0, 11};
    tbl[2] = '{18, 0, 0, 1'b0, 8'h30, 16, 1'b1, 0};
    tbl[3] = '{ 0, 0, 3, 1'b0, 8'h00,  0, 1'b0, 16};
    tbl[4] = '{ 2, 0, 0, 1'b1, 8'hC0,  2, 1'b0, 14};

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_data = 8'h00;
    step();
    step();
    chk("rst_wren", {31'd0, rom_wren}, 0);
    chk("rst_hold", {31'd0, drv_hold}, 1);
    chk("rst_loaded", {31'd0, loaded}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_rom_len", {27'd0, rom_len}, 0);
    chk("rst_addr_data", {20'd0, rom_addr, rom_data}, 0);
    reset = 1'b0;
    step();
    wq.delete();

    // Directed downloads from the vector table.
    for (int t = 0; t < 5; t++) begin
      start_dl();
      for (int i = 0; i < tbl[t].n; i++) strobe(tbl[t].base + 8'(i), tbl[t].gap);
      finish_dl(tbl[t].hold, tbl[t].fall_strobe, tbl[t].exp_len, tbl[t].exp_ovf, tbl[t].exp_fill);
    end

    // Reset in the middle of LOAD with the download still high.
    start_dl();
    for (int i = 0; i < 3; i++) strobe(8'h10 + 8'(i), 0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    wq.delete();
    chk("mid_rst_wren", {31'd0, rom_wren}, 0);
    chk("mid_rst_hold", {31'd0, drv_hold}, 1);
    chk("mid_rst_loaded", {31'd0, loaded}, 0);
    chk("mid_rst_rom_len", {27'd0, rom_len}, 0);
    chk("mid_rst_addr_data", {20'd0, rom_addr, rom_data}, 0);
    repeat (2) step();
    ioctl_wr = 1'b1;
    ioctl_data = 8'h99;
    step();
    step();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (24) step();
    chk("stale_writes", wq.size(), 0);
    chk("stale_hold", {31'd0, drv_hold}, 1);
    chk("stale_loaded", {31'd0, loaded}, 0);

    // Randomised downloads against the image model.
    for (int r = 0; r < 10; r++) begin
      n  = $urandom_range(0, 20);
      fs = (n > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      start_dl();
      for (int i = 0; i < n; i++) strobe(8'($urandom_range(0, 255)), $urandom_range(0, 2));
      elen = (n < RS) ? n : RS;
      finish_dl($urandom_range(0, 3), fs, elen, n > RS, RS - elen);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
